// File: rtl/nf_10g_if_stats_regs.sv
// Per-port AXI4-Lite CSR block for the 10G interface wrapper: ID, scratch, packet counters, MAC/PCS-PMA status.
// Optional feature macro: NF10G_PCSPMA_VECTOR_REGS_EN builds the 14 PCSPMAVEC readback registers.
module nf_10g_if_stats_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12
) (
  input  logic                            core_clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            m_axis_tlast,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [7:0]                      interface_number,
  input  logic [1:0]                      mac_status_vector,
  input  logic [7:0]                      pcspma_status,
  input  logic [447:0]                    pcspma_status_vector
);

  logic        awready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [31:0] rdata_reg;
  logic [31:0] w_reg, d_reg;
  logic [31:0] pktin_reg, pktout_reg;
  logic [7:0]  ifnum_reg;
  logic [1:0]  mac_reg;
  logic [7:0]  pcs_reg;
  logic [31:0] rd_mux;

  logic [4:0]  wr_word, rd_word;
  logic        wr_fire, rd_fire;
  logic        soft_clr, soft_rst;
  logic        pktin_inc, pktout_inc, pktin_clr, pktout_clr;

  assign wr_word  = S_AXI_AWADDR[6:2];
  assign rd_word  = S_AXI_ARADDR[6:2];
  assign wr_fire  = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire  = arready_reg & S_AXI_ARVALID;
  assign soft_clr = wr_fire && (wr_word == 5'd2) && S_AXI_WDATA[0];
  assign soft_rst = wr_fire && (wr_word == 5'd2) && S_AXI_WDATA[4];

  assign pktin_inc  = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign pktout_inc = s_axis_tvalid & s_axis_tready & s_axis_tlast;
  assign pktin_clr  = soft_clr | soft_rst | (rd_fire && (rd_word == 5'd6));
  assign pktout_clr = soft_clr | soft_rst | (rd_fire && (rd_word == 5'd7));

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = awready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;

  // AXI4-Lite handshakes: READY is a single-cycle pulse, responses hold until accepted.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      awready_reg <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_reg & ~awready_reg;
      arready_reg <= S_AXI_ARVALID & ~rvalid_reg & ~arready_reg;
      if (wr_fire)
        bvalid_reg <= 1'b1;
      else if (S_AXI_BREADY)
        bvalid_reg <= 1'b0;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Host scratch words survive the RESET-register soft reset.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      w_reg <= '0;
      d_reg <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b] && wr_word == 5'd3) w_reg[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        if (S_AXI_WSTRB[b] && wr_word == 5'd4) d_reg[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Count field wraps to zero and latches bit31 as a sticky overflow flag.
  always_ff @(posedge core_clk) begin
    if (rst || pktin_clr)
      pktin_reg <= '0;
    else if (pktin_inc)
      pktin_reg <= (&pktin_reg[30:0]) ? 32'h8000_0000 : {pktin_reg[31], pktin_reg[30:0] + 31'd1};
  end

  always_ff @(posedge core_clk) begin
    if (rst || pktout_clr)
      pktout_reg <= '0;
    else if (pktout_inc)
      pktout_reg <= (&pktout_reg[30:0]) ? 32'h8000_0000 : {pktout_reg[31], pktout_reg[30:0] + 31'd1};
  end

  always_ff @(posedge core_clk) begin
    if (rst || soft_rst) begin
      ifnum_reg <= '0;
      mac_reg   <= '0;
      pcs_reg   <= '0;
    end else begin
      ifnum_reg <= interface_number;
      mac_reg   <= mac_status_vector;
      pcs_reg   <= pcspma_status;
    end
  end

`ifdef NF10G_PCSPMA_VECTOR_REGS_EN
  logic [31:0] vec_reg [14];
  logic [3:0]  vec_idx;
  logic        unused_bits;

  assign vec_idx     = 4'(rd_word - 5'd10);
  assign unused_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:7], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:7], S_AXI_ARADDR[1:0]};

  always_ff @(posedge core_clk) begin
    for (int n = 0; n < 14; n++) begin
      if (rst || soft_rst) vec_reg[n] <= '0;
      else                 vec_reg[n] <= pcspma_status_vector[32*n +: 32];
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:7], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:7], S_AXI_ARADDR[1:0],
                         pcspma_status_vector};
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      5'd0: rd_mux = {4'h1, 4'h0, ifnum_reg, 16'hDA03};
      5'd1: rd_mux = 32'h0000_0001;
      5'd3: rd_mux = ~w_reg;
      5'd4: rd_mux = d_reg;
      5'd5: rd_mux = {24'h0, ifnum_reg};
      5'd6: rd_mux = pktin_reg;
      5'd7: rd_mux = pktout_reg;
      5'd8: rd_mux = {30'h0, mac_reg};
      5'd9: rd_mux = {24'h0, pcs_reg};
      default: begin
`ifdef NF10G_PCSPMA_VECTOR_REGS_EN
        if (rd_word >= 5'd10 && rd_word <= 5'd23) rd_mux = vec_reg[vec_idx];
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_nf_10g_if_stats_regs.sv
// Self-checking bench for nf_10g_if_stats_regs: read expectations are queued at issue and popped on RVALID.
module tb_nf_10g_if_stats_regs;

  logic         core_clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  awaddr = '0, araddr = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic         m_tvalid = 0, m_tready = 0, m_tlast = 0;
  logic         s_tvalid = 0, s_tready = 0, s_tlast = 0;
  logic [7:0]   interface_number = 8'h02;
  logic [1:0]   mac_status_vector = '0;
  logic [7:0]   pcspma_status = '0;
  logic [447:0] pcspma_status_vector = '0;

  int           pass_cnt = 0;
  int           chk_cnt = 0;
  logic [31:0]  exp_q[$];
  string        tag_q[$];

  always #5 core_clk = ~core_clk;

  nf_10g_if_stats_regs dut (
    .core_clk(core_clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .interface_number(interface_number), .mac_status_vector(mac_status_vector),
    .pcspma_status(pcspma_status), .pcspma_status_vector(pcspma_status_vector)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge core_clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    do begin @(negedge core_clk); n++; end while (!awready && n < 20);
    check_eq("aw_wait", 32'(n < 20), 32'd1);
    @(posedge core_clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    check_eq("bvalid", 32'(bvalid), 32'd1);
    @(posedge core_clk); #1;
    bready = 0;
    $display("write  addr=0x%03h data=0x%08h strb=%b", a, d, s);
  endtask

  task automatic axi_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
    int n = 0;
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge core_clk);
    araddr = a; arvalid = 1;
    do begin @(negedge core_clk); n++; end while (!arready && n < 20);
    check_eq("ar_wait", 32'(n < 20), 32'd1);
    @(posedge core_clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge core_clk); n++; end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (n >= 20) check_eq({t, "_timeout"}, 32'(rvalid), 32'd1);
    else check_eq(t, rdata, e);
    $display("read   addr=0x%03h data=0x%08h exp=0x%08h (%s)", a, rdata, e, t);
    rready = 1;
    @(posedge core_clk); #1;
    rready = 0;
  endtask

  task automatic rx_beat(input logic rdy, input logic last);
    @(negedge core_clk);
    m_tvalid = 1; m_tready = rdy; m_tlast = last;
    @(negedge core_clk);
    m_tvalid = 0; m_tready = 0; m_tlast = 0;
  endtask

  task automatic tx_beats(input int cnt);
    @(negedge core_clk);
    s_tvalid = 1; s_tready = 1; s_tlast = 1;
    repeat (cnt) @(negedge core_clk);
    s_tvalid = 0; s_tready = 0; s_tlast = 0;
  endtask

  initial begin
    logic [31:0] vec_exp;
    repeat (3) @(negedge core_clk);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 0;
    repeat (2) @(negedge core_clk);

    axi_read("id", 12'h000, 32'h1002_DA03);
    axi_read("version", 12'h004, 32'h0000_0001);
    axi_read("flip_rst", 12'h00C, 32'hFFFF_FFFF);
    axi_read("debug_rst", 12'h010, 32'h0);
    axi_read("ifid", 12'h014, 32'h0000_0002);
    axi_read("reset_reg", 12'h008, 32'h0);
    axi_read("unmapped", 12'h060, 32'h0);
    axi_read("id_alias", 12'h800, 32'h1002_DA03);

    axi_write(12'h00C, 32'h1234_5678, 4'b0011);
    axi_read("flip_strb", 12'h00C, 32'hFFFF_A987);
    axi_write(12'h010, 32'hAA00_0000, 4'b1000);
    axi_read("debug_strb", 12'h010, 32'hAA00_0000);
    axi_write(12'h010, 32'h0000_0005, 4'b1111);
    axi_read("debug", 12'h010, 32'h0000_0005);
    axi_write(12'h070, 32'hFFFF_FFFF, 4'b1111);
    axi_read("unmapped_wr", 12'h070, 32'h0);

    mac_status_vector = 2'b10;
    pcspma_status = 8'h5A;
    axi_read("macstatus", 12'h020, 32'h2);
    axi_read("pcsstatus", 12'h024, 32'h5A);

    // Five tlast beats (one stalled) and one non-last beat.
    rx_beat(1, 1); rx_beat(1, 1); rx_beat(0, 1); rx_beat(1, 1); rx_beat(1, 1);
    rx_beat(1, 0);
    axi_read("pktin", 12'h018, 32'd4);
    axi_read("pktin_cor", 12'h018, 32'd0);

    // Beats on the cycles before, at and after the clear handshake; the middle one is lost.
    axi_read("pktout_pre", 12'h01C, 32'd0);
    fork
      tx_beats(3);
      axi_read("pktout_race", 12'h01C, 32'd1);
    join
    axi_read("pktout_after", 12'h01C, 32'd1);

    @(negedge core_clk);
    force dut.pktin_reg = 32'h7FFF_FFFF;
    @(negedge core_clk);
    release dut.pktin_reg;
    rx_beat(1, 1);
    axi_read("pktin_wrap", 12'h018, 32'h8000_0000);
    rx_beat(1, 1);
    axi_read("pktin_after_wrap", 12'h018, 32'h0000_0001);

    rx_beat(1, 1); rx_beat(1, 1);
    axi_write(12'h008, 32'h0000_0001, 4'b1111);
    axi_read("pktin_clr", 12'h018, 32'd0);

    rx_beat(1, 1); rx_beat(1, 1); rx_beat(1, 1);
    tx_beats(2);
    axi_write(12'h008, 32'h0000_0010, 4'b1111);
    axi_read("pktin_srst", 12'h018, 32'd0);
    axi_read("pktout_srst", 12'h01C, 32'd0);
    axi_read("debug_kept", 12'h010, 32'h0000_0005);
    axi_read("flip_kept", 12'h00C, 32'hFFFF_A987);

    pcspma_status_vector[31:0]    = 32'h1111_2222;
    pcspma_status_vector[63:32]   = 32'hCAFE_F00D;
    pcspma_status_vector[447:416] = 32'hDEAD_BEEF;
`ifdef NF10G_PCSPMA_VECTOR_REGS_EN
    vec_exp = 32'hCAFE_F00D;
    axi_read("vec0", 12'h028, 32'h1111_2222);
    axi_read("vec13", 12'h05C, 32'hDEAD_BEEF);
`else
    vec_exp = 32'h0;
    axi_read("vec0", 12'h028, 32'h0);
    axi_read("vec13", 12'h05C, 32'h0);
`endif
    axi_read("vec1", 12'h02C, vec_exp);

    // Reset landing while BVALID is pending drops the response and the scratch word.
    @(negedge core_clk);
    awaddr = 12'h010; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    begin
      int n = 0;
      do begin @(negedge core_clk); n++; end while (!awready && n < 20);
      check_eq("aw_wait_rst", 32'(n < 20), 32'd1);
    end
    @(posedge core_clk); #1;
    awvalid = 0; wvalid = 0;
    rst = 1;
    @(posedge core_clk); #1;
    check_eq("bvalid_dropped", 32'(bvalid), 32'd0);
    rst = 0;
    repeat (2) @(negedge core_clk);
    axi_read("debug_after_rst", 12'h010, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nf_10g_if_stats_regs.md
# nf_10g_if_stats_regs

Per-port control/status register block for the 10G shared-logic interface wrapper. It exposes identification, scratch, packet-counter and MAC/PCS-PMA status registers to the host over AXI4-Lite. It taps the RX (10GE→DMA) and TX (DMA→10GE) AXI-Stream handshakes without driving them. It sits beside the MAC/PCS-PMA core in the interface wrapper, on the core clock.

## Interface
- C_S_AXI_DATA_WIDTH, 32, register/bus data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 12, byte address width; decode uses ADDR[6:2], upper bits ignored
- core_clk  in  1  single clock for all logic, including AXI4-Lite
- rst  in  1  reset; synchronous, active-high
- S_AXI_AWADDR/ARADDR  in  12  write/read address
- S_AXI_AWVALID/WVALID/BREADY/ARVALID/RREADY  in  1  AXI4-Lite handshakes
- S_AXI_WDATA  in  32 ; S_AXI_WSTRB  in  4  write data, byte enables
- S_AXI_AWREADY/WREADY/BVALID/ARREADY/RVALID  out  1  AXI4-Lite handshakes
- S_AXI_BRESP/RRESP  out  2  always 2'b00; S_AXI_RDATA  out  32  read data
- m_axis_tvalid/tready/tlast  in  1  RX stream tap
- s_axis_tvalid/tready/tlast  in  1  TX stream tap
- interface_number  in  8  port index
- mac_status_vector  in  2 ; pcspma_status  in  8 ; pcspma_status_vector  in  448  core status

## Operation
- Register map (word offsets): 0x00 ID, 0x04 VERSION, 0x08 RESET, 0x0C FLIP, 0x10 DEBUG, 0x14 INTERFACEID, 0x18 PKTIN, 0x1C PKTOUT, 0x20 MACSTATUS, 0x24 PCSPMASTATUS, 0x28+4n PCSPMAVEC n (n=0..13). Unmapped: read 0, write ignored, OKAY.
- ID = {4'h1, 4'h0, interface_number, 16'hDA03}; VERSION = 32'h0000_0001.
- INTERFACEID = {24'h0, interface_number}.
- FLIP: host-written word W (reset 0); reads return ~W.
- DEBUG: host-written word D (reset 0); reads return D.
- FLIP/DEBUG writes honor WSTRB per byte.
- RESET: writes produce a one-cycle pulse; the register is not stored and reads 0.
  - bit0 = clear counters.
  - bit4 = reset all readback registers and counters to reset values; W and D are kept.
- PKTIN counts cycles with m_axis_tvalid&tready&tlast; PKTOUT counts the same on s_axis_*.
- Counter format: bits[30:0] count and wrap 0x7FFF_FFFF→0; bit31 is a sticky overflow flag, set on wrap.
- Counters clear on host read. Clear, bit0 and bit4 each zero all 32 bits.
- Clear beats a coincident increment; that event is lost.
- MACSTATUS = {30'h0, mac_status_vector}; PCSPMASTATUS = {24'h0, pcspma_status}; PCSPMAVEC n = pcspma_status_vector[32n+31:32n].
- Reset values: all AXI outputs 0, RDATA 0, counters 0, status regs 0, W = D = 0.

## Timing
- Readback registers resample inputs every cycle with 1-cycle latency.
- A FLIP/DEBUG write is visible on read 2 cycles after the write handshake.
- Write: AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID. BVALID rises the next cycle and holds until BREADY.
- Read: ARREADY pulses for one cycle when ARVALID & !RVALID. RDATA/RVALID follow the next cycle; RVALID holds until RREADY, and RDATA stays stable while it does.
- Clear-on-read: RDATA captures the pre-clear value; the counter is 0 on the cycle after ARREADY.
- rst mid-transaction drops pending BVALID/RVALID and the transaction is lost.

## Configuration
- NF10G_PCSPMA_VECTOR_REGS_EN defined: PCSPMAVEC0..13 are implemented as above.
- Not defined: the 14 PCSPMAVEC registers are not built, offsets 0x28–0x5C read 0, and pcspma_status_vector is ignored.

## Test plan
- After rst with interface_number=8'h02: ID reads 32'h1002_DA03, VERSION reads 1, FLIP reads 32'hFFFF_FFFF.
- Write FLIP=32'h1234_5678 with WSTRB=4'b0011: FLIP reads 32'hFFFF_A987. Write DEBUG=5: DEBUG reads 5.
- Five RX tlast beats, one with tready=0: PKTIN reads 4, and an immediate reread gives 0. Three TX beats concurrent with a PKTOUT read: each beat is counted once or lost only on the clear cycle.
- Preload PKTIN to 0x7FFF_FFFF and add one beat: PKTIN reads 0x8000_0000.
- Write RESET=0x10 after DEBUG=5: counters and status regs become 0, and DEBUG still reads 5.
- Drive pcspma_status_vector[63:32]=32'hCAFE_F00D: offset 0x2C reads that value with the macro defined, and 0 without it.
